bus_src_arbiter: RTL and testbench
==================================

// Module: bus_src_arbiter
// PURPOSE
//  Round-robin arbiter that shares the 16-bit internal source bus among 3 requesters
//  (sources 0/1/2 = mux data inputs 1/2/3) and drives the 2-bit select of the 3-input bus mux.
//  Enforces a burst limit per grant and a 1-cycle turnaround (sel=2'b11, mux output Z)
//  between owners, preventing overlapping drivers. Sits beside the bus mux in the datapath.
// PARAMETERS
//  MAX_HOLD  8  max consecutive grant cycles while another source waits; legal range 1..255
// PORTS
//  clk        in   1  single clock; all state updates on rising edge
//  rst_n      in   1  asynchronous, active-low reset
//  req        in   3  req[i]=1: source i wants the bus; level-sensitive, held until done
//  gnt        out  3  one-hot grant, registered; 3'b000 when no owner
//  sel        out  2  mux select, registered: 2'b00/01/10 = owner 0/1/2; 2'b11 = no driver
//  busy       out  1  1 while in GRANT state
//  hold_cnt   out  8  cycles the current owner has held the bus, 1..MAX_HOLD; 0 when not GRANT
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, gnt=0, sel=2'b11, busy=0, hold_cnt=0,
//   last_owner=2 (first search order 0,1,2). Reset mid-grant drops the bus immediately.
//  States: IDLE, GRANT, TURN. All outputs are registered functions of state/owner.
//  Search order: last_owner+1, last_owner+2, last_owner (mod 3); first set req wins.
//  IDLE: any req at edge -> GRANT to search winner; gnt/sel visible the cycle after req seen.
//   No req -> stay IDLE.
//  GRANT: hold_cnt=1 on first grant cycle, +1 per further cycle, saturating at MAX_HOLD.
//   - req[owner]=0 at edge -> TURN.
//   - hold_cnt==MAX_HOLD and another req set -> TURN (forced release; the grant lasts
//     exactly MAX_HOLD cycles).
//   - hold_cnt==MAX_HOLD and no other req -> stay GRANT; hold_cnt restarts at 1.
//   - else stay GRANT.
//  Entering TURN: last_owner <= owner, gnt=0, sel=2'b11, busy=0, hold_cnt=0.
//  TURN: lasts exactly 1 cycle. Any req -> GRANT to search winner (may be the same
//   source again only if it is the sole requester). No req -> IDLE.
//  Gap between two different owners is exactly 1 cycle with sel=2'b11.
//  sel never takes a value that disagrees with gnt; gnt is always one-hot or zero.
//  Requests rising or falling during TURN are sampled only at the TURN->next edge.
//  Simultaneous owner drop and hold limit -> TURN (same result).
//  MAX_HOLD=1: every grant lasts 1 cycle when others wait; a sole requester stays granted.
// TESTING
//  1 Reset: rst_n=0 mid-GRANT -> gnt=0, sel=11, busy=0 same cycle, no clock needed.
//  2 Single req=3'b010 held 5 cycles, then 0 -> gnt=010, sel=01 for 5 cycles, 1 TURN
//    cycle, IDLE.
//  3 req=3'b111 constant, MAX_HOLD=8 -> owners 0,1,2,0... each 8 cycles, 1-cycle
//    sel=11 gap.
//  4 req=3'b001 held 20 cycles, MAX_HOLD=8 -> continuous grant 0; hold_cnt 1..8,1..8,1..4.
//  5 Owner 1 drops req, req=3'b101 during TURN -> next grant is source 2, not source 0.
//  6 MAX_HOLD=1, req=3'b011 -> grant alternates 0,1 with TURN between; hold_cnt always 1.

Source files
------------

// File: rtl/bus_src_arbiter.sv
// Round-robin owner selection for the shared 16-bit source bus: one-hot grant plus mux select,
// a per-grant burst limit, and a one-cycle undriven turnaround between owners.
module bus_src_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    output logic [2:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic [7:0] hold_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    state_t     state_reg, state_next;
    logic [1:0] owner_reg, owner_next;
    logic [1:0] last_reg, last_next;
    logic [7:0] hold_reg, hold_next;
    logic [2:0] gnt_reg, gnt_next;
    logic [1:0] sel_reg, sel_next;

    logic [2:0] others;
    logic [1:0] cand_1, cand_2, winner;
    logic       owner_req;
    logic       at_limit;

    // Requests from anyone other than the current owner.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_others
            assign others[gi] = req[gi] && (owner_reg != 2'(gi));
        end
    endgenerate

    function automatic logic [1:0] next_src(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Search starts just after the previous owner and wraps back to it last.
    assign cand_1    = next_src(last_reg);
    assign cand_2    = next_src(cand_1);
    assign winner    = req[cand_1] ? cand_1 : (req[cand_2] ? cand_2 : last_reg);
    assign owner_req = req[owner_reg];
    assign at_limit  = (hold_reg == HOLD_MAX);

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        last_next  = last_reg;
        hold_next  = hold_reg;
        case (state_reg)
            IDLE, TURN: begin
                if (|req) begin
                    state_next = GRANT;
                    owner_next = winner;
                    hold_next  = 8'd1;
                end else begin
                    state_next = IDLE;
                    hold_next  = 8'd0;
                end
            end
            GRANT: begin
                if (!owner_req || (at_limit && (|others))) begin
                    state_next = TURN;
                    last_next  = owner_reg;
                    hold_next  = 8'd0;
                end else if (at_limit) begin
                    hold_next = 8'd1;
                end else begin
                    hold_next = hold_reg + 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
                hold_next  = 8'd0;
            end
        endcase

        // gnt and sel come from the same next-state decode, so they can never disagree.
        gnt_next = 3'b000;
        sel_next = 2'b11;
        if (state_next == GRANT) begin
            gnt_next = 3'b001 << owner_next;
            sel_next = owner_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            owner_reg <= 2'd0;
            last_reg  <= 2'd2;
            hold_reg  <= 8'd0;
            gnt_reg   <= 3'b000;
            sel_reg   <= 2'b11;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            last_reg  <= last_next;
            hold_reg  <= hold_next;
            gnt_reg   <= gnt_next;
            sel_reg   <= sel_next;
        end
    end

    assign gnt      = gnt_reg;
    assign sel      = sel_reg;
    assign busy     = (state_reg == GRANT);
    assign hold_cnt = hold_reg;

endmodule

// File: tb/tb_bus_src_arbiter.sv
// Drives two arbiters (hold limits 8 and 1) with the same request stream and compares every
// output each cycle against an ownership model built from the arbitration rules.
module tb_bus_src_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] req = 3'b000;

    logic [2:0] a_gnt, b_gnt;
    logic [1:0] a_sel, b_sel;
    logic       a_busy, b_busy;
    logic [7:0] a_hold, b_hold;

    bus_src_arbiter #(.MAX_HOLD(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(a_gnt), .sel(a_sel), .busy(a_busy), .hold_cnt(a_hold)
    );

    bus_src_arbiter #(.MAX_HOLD(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(b_gnt), .sel(b_sel), .busy(b_busy), .hold_cnt(b_hold)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: owner (-1 = nobody drives), cycles held, previous owner.
    int m_own[2];
    int m_cnt[2];
    int m_last[2];
    int m_max[2] = '{8, 1};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_own[i]  = -1;
            m_cnt[i]  = 0;
            m_last[i] = 2;
        end
    endtask

    task automatic model_step(input logic [2:0] r);
        for (int i = 0; i < 2; i++) begin
            if (m_own[i] >= 0) begin
                int others;
                others = 0;
                for (int s = 0; s < 3; s++)
                    if (s != m_own[i] && r[s]) others = 1;
                if (!r[m_own[i]] || (m_cnt[i] == m_max[i] && others != 0)) begin
                    m_last[i] = m_own[i];
                    m_own[i]  = -1;
                    m_cnt[i]  = 0;
                end else begin
                    m_cnt[i] = (m_cnt[i] == m_max[i]) ? 1 : m_cnt[i] + 1;
                end
            end else if (r != 3'b000) begin
                for (int k = 1; k <= 3; k++) begin
                    int s;
                    s = (m_last[i] + k) % 3;
                    if (r[s] && m_own[i] < 0) m_own[i] = s;
                end
                m_cnt[i] = 1;
                if (i == 0)
                    $display("grant src=%0d req=%b hold_limit=%0d t=%0t", m_own[i], r, m_max[i], $time);
            end
        end
    endtask

    function automatic logic [2:0] exp_gnt(input int i);
        return (m_own[i] < 0) ? 3'b000 : 3'(1 << m_own[i]);
    endfunction

    function automatic logic [1:0] exp_sel(input int i);
        return (m_own[i] < 0) ? 2'b11 : 2'(m_own[i]);
    endfunction

    task automatic check_all(input string ph);
        check({ph, "_a_gnt"},  32'(a_gnt),  32'(exp_gnt(0)));
        check({ph, "_a_sel"},  32'(a_sel),  32'(exp_sel(0)));
        check({ph, "_a_busy"}, 32'(a_busy), 32'(m_own[0] >= 0));
        check({ph, "_a_hold"}, 32'(a_hold), 32'(m_cnt[0]));
        check({ph, "_b_gnt"},  32'(b_gnt),  32'(exp_gnt(1)));
        check({ph, "_b_sel"},  32'(b_sel),  32'(exp_sel(1)));
        check({ph, "_b_busy"}, 32'(b_busy), 32'(m_own[1] >= 0));
        check({ph, "_b_hold"}, 32'(b_hold), 32'(m_cnt[1]));
    endtask

    task automatic cycle(input string ph, input logic [2:0] r);
        req = r;
        @(posedge clk);
        model_step(r);
        #1;
        check_all(ph);
    endtask

    logic [2:0] rnd_req;

    initial begin
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // single requester, then release
        repeat (5) cycle("single", 3'b010);
        repeat (2) cycle("single_rel", 3'b000);

        // all requesting: rotation with burst limit
        repeat (30) cycle("all", 3'b111);
        repeat (2) cycle("all_rel", 3'b000);

        // sole requester past the limit keeps the bus
        repeat (20) cycle("sole", 3'b001);
        repeat (2) cycle("sole_rel", 3'b000);

        // owner 1 drops; 0 and 2 appear during turnaround -> 2 wins
        repeat (2) cycle("drop", 3'b010);
        cycle("drop_turn", 3'b000);
        cycle("drop_next", 3'b101);
        check("drop_src2", 32'(a_gnt), 32'(3'b100));
        repeat (2) cycle("drop_rel", 3'b000);

        // two requesters alternate
        repeat (12) cycle("pair", 3'b011);

        // asynchronous reset in the middle of a grant
        repeat (3) cycle("pre_rst", 3'b111);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        req = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;

        // random level-held requests
        rnd_req = 3'b000;
        repeat (600) begin
            for (int b = 0; b < 3; b++)
                if ($urandom_range(0, 3) == 0) rnd_req[b] = ~rnd_req[b];
            cycle("rand", rnd_req);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
